// File: rtl/sifive_insight_tl_arb_pkg.sv
// Shared types for the TileLink A-channel prot arbiter.
// amba_prot_t, TL opcodes, arbiter FSM states.
package sifive_insight_tl_arb_pkg;

  typedef struct packed {
    logic bufferable;
    logic modifiable;
    logic readalloc;
    logic writealloc;
    logic privileged;
    logic secure;
    logic fetch;
  } amba_prot_t;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic logic is_put(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/sifive_insight_rr_pick.sv
// Rotate-priority picker: first set req bit scanning ptr, ptr+1, ...
// Ports: req, ptr in; grant (one-hot), idx, found out.
module sifive_insight_rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c = IW'((int'(ptr) + i) % N);
      if (!found && req[c]) begin
        found    = 1'b1;
        idx      = c;
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sifive_insight_tl_a_prot_arbiter.sv
// Round-robin TL-A arbiter with amba_prot tagging and Put burst lock.
// Ports: clock, reset_n; in_* per requester (valid/ready, A fields,
// in_prot); out_* muxed winner (valid/ready, A fields, out_prot); busy.
// SIFIVE_INSIGHT_PROT_CHECK_EN adds prot_err and prot_err_cnt.
module sifive_insight_tl_a_prot_arbiter
  import sifive_insight_tl_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SRC_W  = 4,
  parameter int SIZE_W = 4,
  parameter logic [NREQ-1:0] FETCH_MASK = 'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             in_valid,
  output logic [NREQ-1:0]             in_ready,
  input  logic [NREQ*3-1:0]           in_opcode,
  input  logic [NREQ*3-1:0]           in_param,
  input  logic [NREQ*SIZE_W-1:0]      in_size,
  input  logic [NREQ*SRC_W-1:0]       in_source,
  input  logic [NREQ*ADDR_W-1:0]      in_address,
  input  logic [NREQ*(DATA_W/8)-1:0]  in_mask,
  input  logic [NREQ*DATA_W-1:0]      in_data,
  input  logic [NREQ*7-1:0]           in_prot,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2:0]                  out_opcode,
  output logic [2:0]                  out_param,
  output logic [SIZE_W-1:0]           out_size,
  output logic [SRC_W-1:0]            out_source,
  output logic [ADDR_W-1:0]           out_address,
  output logic [DATA_W/8-1:0]         out_mask,
  output logic [DATA_W-1:0]           out_data,
  output logic [6:0]                  out_prot,
`ifdef SIFIVE_INSIGHT_PROT_CHECK_EN
  output logic                        prot_err,
  output logic [7:0]                  prot_err_cnt,
`endif
  output logic                        busy
);

  localparam int BB     = DATA_W / 8;
  localparam int IW     = $clog2(NREQ);
  localparam int LOG_BB = $clog2(BB);
  localparam int MAX_LG = (1 << SIZE_W) - 1;
  localparam int CNT_W  = (MAX_LG > LOG_BB) ? MAX_LG - LOG_BB + 1 : 1;

  arb_state_e      state, state_nx;
  logic [IW-1:0]   rr_ptr, lock_id, hold_id, sel, pick_idx;
  logic            hold_v, pick_found, fire, first;
  logic [NREQ-1:0] pick_gnt, sel_oh;
  logic [CNT_W-1:0] beat_cnt, beats;
  amba_prot_t      prot_q, prot_sel;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
  endfunction

  sifive_insight_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (first && beats != CNT_W'(1)) state_nx = BURST;
      BURST:   if (fire && beat_cnt == CNT_W'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A stalled winner in IDLE stays selected until taken (hold_v).
  always_comb begin
    busy      = (state == BURST);
    sel       = pick_idx;
    out_valid = pick_found;
    sel_oh    = pick_gnt;
    if (busy) begin
      sel       = lock_id;
      out_valid = in_valid[lock_id];
      sel_oh    = NREQ'(1) << lock_id;
    end else if (hold_v) begin
      sel       = hold_id;
      out_valid = in_valid[hold_id];
      sel_oh    = NREQ'(1) << hold_id;
    end
    in_ready = (out_valid && out_ready) ? sel_oh : '0;
  end

  assign fire  = out_valid && out_ready;
  assign first = fire && (state == IDLE);

  always_comb begin
    out_opcode  = '0;
    out_param   = '0;
    out_size    = '0;
    out_source  = '0;
    out_address = '0;
    out_mask    = '0;
    out_data    = '0;
    out_prot    = '0;
    prot_sel    = amba_prot_t'(in_prot[int'(sel)*7 +: 7]);
    prot_sel.fetch = prot_sel.fetch | FETCH_MASK[sel];
    if (out_valid) begin
      out_opcode  = in_opcode[int'(sel)*3 +: 3];
      out_param   = in_param[int'(sel)*3 +: 3];
      out_size    = in_size[int'(sel)*SIZE_W +: SIZE_W];
      out_source  = in_source[int'(sel)*SRC_W +: SRC_W];
      out_address = in_address[int'(sel)*ADDR_W +: ADDR_W];
      out_mask    = in_mask[int'(sel)*BB +: BB];
      out_data    = in_data[int'(sel)*DATA_W +: DATA_W];
      out_prot    = busy ? prot_q : prot_sel;
    end
  end

  always_comb begin
    beats = CNT_W'(1);
    if (is_put(out_opcode) && int'(out_size) > LOG_BB)
      beats = CNT_W'(1) << (int'(out_size) - LOG_BB);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      lock_id  <= '0;
      beat_cnt <= '0;
      prot_q   <= '0;
      hold_v   <= 1'b0;
      hold_id  <= '0;
    end else begin
      if (fire) begin
        hold_v <= 1'b0;
      end else if (out_valid && !busy) begin
        hold_v  <= 1'b1;
        hold_id <= sel;
      end
      if (first) begin
        if (beats != CNT_W'(1)) begin
          lock_id  <= sel;
          beat_cnt <= beats - CNT_W'(1);
          prot_q   <= prot_sel;
        end else begin
          rr_ptr <= nxt(sel);
        end
      end else if (fire && busy) begin
        beat_cnt <= beat_cnt - CNT_W'(1);
        if (beat_cnt == CNT_W'(1)) rr_ptr <= nxt(lock_id);
      end
    end
  end

`ifdef SIFIVE_INSIGHT_PROT_CHECK_EN
  logic err_ev;

  assign err_ev = first && (out_opcode != GET) &&
                  (FETCH_MASK[sel] || in_prot[int'(sel)*7]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prot_err     <= 1'b0;
      prot_err_cnt <= '0;
    end else if (err_ev) begin
      prot_err <= 1'b1;
      if (prot_err_cnt != 8'hff) prot_err_cnt <= prot_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sifive_insight_tl_a_prot_arbiter.sv
// Bench for the TL-A prot arbiter: directed steps plus random traffic
// against a message-level queue model.
module tb_sifive_insight_tl_a_prot_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 4;
  localparam int IW = 4;
  localparam int BB = DW / 8;
  localparam logic [N-1:0] FM = 3'b001;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] in_valid, in_ready;
  logic [N*3-1:0] in_opcode, in_param;
  logic [N*SW-1:0] in_size;
  logic [N*IW-1:0] in_source;
  logic [N*AW-1:0] in_address;
  logic [N*BB-1:0] in_mask;
  logic [N*DW-1:0] in_data;
  logic [N*7-1:0] in_prot;
  logic out_valid, out_ready, busy;
  logic [2:0] out_opcode, out_param;
  logic [SW-1:0] out_size;
  logic [IW-1:0] out_source;
  logic [AW-1:0] out_address;
  logic [BB-1:0] out_mask;
  logic [DW-1:0] out_data;
  logic [6:0] out_prot;
`ifdef SIFIVE_INSIGHT_PROT_CHECK_EN
  logic prot_err;
  logic [7:0] prot_err_cnt;
`endif

  sifive_insight_tl_a_prot_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_param(in_param),
    .in_size(in_size), .in_source(in_source),
    .in_address(in_address), .in_mask(in_mask),
    .in_data(in_data), .in_prot(in_prot),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_param(out_param),
    .out_size(out_size), .out_source(out_source),
    .out_address(out_address), .out_mask(out_mask),
    .out_data(out_data), .out_prot(out_prot),
`ifdef SIFIVE_INSIGHT_PROT_CHECK_EN
    .prot_err(prot_err), .prot_err_cnt(prot_err_cnt),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [3:0]  src;
    logic [31:0] addr;
  } msg_t;

  msg_t q[N][$];
  logic [DW-1:0] bd[N];
  logic [BB-1:0] bm[N];
  logic [6:0]    bp[N];
  int ptr, lock, hold, rem, ecnt;
  logic [6:0] lprot, obs_prot, st_prot;
  logic [DW-1:0] obs_data, st_data;
  int grants[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic msg_t mk(input logic [2:0] op, input logic [3:0] sz);
    msg_t m;
    m.op = op;
    m.param = 3'($urandom);
    m.size = sz;
    m.src = 4'($urandom);
    m.addr = $urandom;
    return m;
  endfunction

  function automatic msg_t rmsg();
    int k;
    k = $urandom % 4;
    return mk((k == 0) ? 3'd0 : (k == 1) ? 3'd1 : 3'd4, 4'($urandom % 7));
  endfunction

  // A Put covers 2^size bytes at BB bytes per beat.
  function automatic int nbeats(input msg_t m);
    if (m.op <= 3'd1 && (1 << m.size) > BB) return (1 << m.size) / BB;
    return 1;
  endfunction

  function automatic int pend();
    int t;
    t = 0;
    for (int r = 0; r < N; r++) t += q[r].size();
    return t;
  endfunction

  function automatic int exp_sel();
    if (lock >= 0) return lock;
    if (hold >= 0) return hold;
    for (int i = 0; i < N; i++)
      if (q[(ptr + i) % N].size() > 0) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic drive();
    in_valid = '0; in_opcode = '0; in_param = '0; in_size = '0;
    in_source = '0; in_address = '0;
    for (int r = 0; r < N; r++) begin
      in_prot[r*7 +: 7] = bp[r];
      in_data[r*DW +: DW] = bd[r];
      in_mask[r*BB +: BB] = bm[r];
      if (q[r].size() > 0) begin
        in_valid[r] = 1'b1;
        in_opcode[r*3 +: 3] = q[r][0].op;
        in_param[r*3 +: 3] = q[r][0].param;
        in_size[r*SW +: SW] = q[r][0].size;
        in_source[r*IW +: IW] = q[r][0].src;
        in_address[r*AW +: AW] = q[r][0].addr;
      end
    end
  endtask

  task automatic accept(input int s);
    int nb;
    logic [6:0] p;
    hold = -1;
    if (lock < 0) begin
      nb = nbeats(q[s][0]);
      grants.push_back(s);
      p = bp[s];
      p[0] = p[0] | FM[s];
      if (q[s][0].op != 3'd4 && (FM[s] || bp[s][0]) && ecnt < 255) ecnt++;
      if (nb > 1) begin
        lock = s; rem = nb - 1; lprot = p;
      end else begin
        void'(q[s].pop_front());
        ptr = (s + 1) % N;
      end
    end else begin
      rem--;
      if (rem == 0) begin
        void'(q[s].pop_front());
        ptr = (lock + 1) % N;
        lock = -1;
      end
    end
    bd[s] = {$urandom, $urandom};
    bm[s] = BB'($urandom);
    bp[s] = 7'($urandom);
  endtask

  task automatic cycle(input bit rdy);
    int s;
    logic [N-1:0] er;
    logic [6:0] ep;
    drive();
    out_ready = rdy;
    @(negedge clock);
    s = exp_sel();
    er = '0;
    obs_prot = out_prot;
    obs_data = out_data;
    chk("out_valid", out_valid, s >= 0);
    chk("busy", busy, lock >= 0);
`ifdef SIFIVE_INSIGHT_PROT_CHECK_EN
    chk("prot_err", prot_err, ecnt > 0);
    chk("prot_err_cnt", prot_err_cnt, ecnt);
`endif
    if (s >= 0) begin
      if (rdy) er[s] = 1'b1;
      if (lock >= 0) ep = lprot;
      else begin
        ep = bp[s];
        ep[0] = ep[0] | FM[s];
      end
      chk("in_ready", in_ready, er);
      chk("out_hdr", {out_opcode, out_param, out_size, out_source},
          {q[s][0].op, q[s][0].param, q[s][0].size, q[s][0].src});
      chk("out_address", out_address, q[s][0].addr);
      chk("out_data", out_data, bd[s]);
      chk("out_mask", out_mask, bm[s]);
      chk("out_prot", out_prot, ep);
      if (!rdy && lock < 0) hold = s;
    end else begin
      chk("in_ready_idle", in_ready, er);
      chk("out_prot_idle", out_prot, 7'h00);
      chk("out_data_idle", out_data, 64'h0);
    end
    @(posedge clock);
    #1;
    if (rdy && s >= 0) accept(s);
  endtask

  task automatic model_reset();
    for (int r = 0; r < N; r++) q[r].delete();
    ptr = 0; lock = -1; hold = -1; rem = 0; ecnt = 0;
  endtask

  initial begin
    out_ready = 1'b0;
    for (int r = 0; r < N; r++) begin
      bd[r] = {$urandom, $urandom};
      bm[r] = BB'($urandom);
      bp[r] = 7'($urandom);
    end
    model_reset();

    cycle(1);
    cycle(1);
    reset_n = 1'b1;
    cycle(1);

    for (int r = 0; r < N; r++) begin
      q[r].push_back(mk(3'd4, 4'd3));
      q[r].push_back(mk(3'd4, 4'd3));
    end
    grants.delete();
    for (int k = 0; k < 6; k++) cycle(1);
    chk("rr_count", grants.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("rr_order", (k < grants.size()) ? grants[k] : -1, k % 3);

    bp[0] = 7'h00;
    q[0].push_back(mk(3'd4, 4'd2));
    cycle(1);
    chk("fetch_force_req0", obs_prot, 7'h01);

    q[0].push_back(mk(3'd4, 4'd3));
    q[1].push_back(mk(3'd0, 4'd5));
    q[2].push_back(mk(3'd4, 4'd3));
    grants.delete();
    cycle(1);
    cycle(0);
    st_data = obs_data;
    st_prot = obs_prot;
    cycle(0);
    chk("stall_data", obs_data, st_data);
    chk("stall_prot", obs_prot, st_prot);
    cycle(0);
    chk("stall_data", obs_data, st_data);
    chk("stall_busy", busy, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1);
    chk("burst_grants", grants.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("burst_order", (k < grants.size()) ? grants[k] : -1,
          (k == 0) ? 1 : (k == 1) ? 2 : 0);

    bp[2] = 7'h00;
    q[2].push_back(mk(3'd4, 4'd2));
    cycle(1);
    chk("fetch_force_req2", obs_prot, 7'h00);

    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < N; r++)
        if (q[r].size() < 3 && ($urandom % 4) == 0) q[r].push_back(rmsg());
      cycle(($urandom % 4) != 0);
    end
    for (int k = 0; k < 2000 && pend() > 0; k++) cycle(1);
    chk("drain", pend(), 0);

    q[0].push_back(mk(3'd4, 4'd3));
    cycle(1);
    q[1].push_back(mk(3'd0, 4'd5));
    cycle(1);
    cycle(1);
    reset_n = 1'b0;
    model_reset();
    drive();
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    cycle(1);
    reset_n = 1'b1;
    q[0].push_back(mk(3'd4, 4'd3));
    q[2].push_back(mk(3'd4, 4'd3));
    grants.delete();
    cycle(1);
    chk("rst_next_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    cycle(1);

`ifdef SIFIVE_INSIGHT_PROT_CHECK_EN
    bp[0] = 7'h00;
    q[0].push_back(mk(3'd0, 4'd3));
    grants.delete();
    cycle(1);
    chk("perr_flag", prot_err, 1'b1);
    chk("perr_cnt", prot_err_cnt, 8'd1);
    chk("perr_fwd", grants.size(), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
